binary_morph_3x3: RTL
=====================

Name: binary_morph_3x3

Overview:
- Post-processing stage directly downstream of the adaptive-threshold segmentation stage.
- Consumes its binary video stream (0x00/0xFF pixels with hsync/vsync/de) and applies 3x3 binary erosion or dilation, or passes the stream through unchanged.
- Removes isolated noise pixels or fills pinholes before the display/overlay stage.
- Contains its own 1-bit line buffers; does not reuse the 8-bit window generator.

Parameters:
- H_DISP, 12'd640, active pixels per line.
- V_DISP, 12'd480, active lines per frame.
- DLY_CYCLE, 3, pipeline latency in clocks (fixed; exposed for the sync delay line only).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  00 bypass, 01 erode, 10 dilate, 11 bypass; sampled only at frame start.
- seg_hsync  in  1  input line sync.
- seg_vsync  in  1  input frame sync, active-high.
- seg_data  in  8  input binary pixel; bit 7 is the pixel value.
- seg_de  in  1  input data enable.
- morph_hsync  out  1  seg_hsync delayed DLY_CYCLE clocks.
- morph_vsync  out  1  seg_vsync delayed DLY_CYCLE clocks.
- morph_data  out  8  8'hFF or 8'h00.
- morph_de  out  1  seg_de delayed DLY_CYCLE clocks.

Behaviour:
- Reset: all outputs 0, counters 0, window 0, mode_lat = 00. Line-buffer contents are don't-care and must never reach the output before being rewritten.
- Frame start: on the rising edge of seg_vsync (registered edge detect):
  - col and row clear to 0;
  - mode_lat <= mode.
- A mode change mid-frame has no effect until the next rising vsync edge.
- Counters advance only on seg_de = 1:
  - col increments, wrapping H_DISP-1 -> 0;
  - on wrap, row increments, saturating at V_DISP-1.
  - When seg_de = 0, counters, window and line buffers hold.
- Line buffers: two H_DISP x 1-bit rows, indexed by col. On de:
  - lb1[col] <= pix;
  - lb0[col] <= old lb1[col];
  - taps read the old values in the same cycle (read-before-write).
- clk1, window update on de: shift the window left by one column, then load the new right column {lb0[col], lb1[col], pix} as rows r-2, r-1, r.
  - Padding at col == 0: the two retained (left) columns load 0.
  - Padding at row == 0: the r-1 and r-2 taps of the new column are forced 0.
  - Padding at row == 1: the r-2 tap is forced 0.
- Window position: the window covers rows r-2..r and cols c-2..c. The result is associated with the window centre (r-1, c-1), one line and one pixel behind the input, the same convention as the upstream stage. The right and bottom borders are not re-emitted.
- clk2, reduce: and9 = AND of the 9 taps; or9 = OR of the 9 taps; ctr = centre tap.
- clk3, output register:
  - morph_data = 8'hFF if the selected bit (erode -> and9, dilate -> or9, bypass -> ctr) is 1, else 8'h00.
  - When the delayed de is 0, morph_data = 8'h00.
- Sync outputs come from 3-deep shift registers updated every clock (not gated by de). Latency is exactly 3 clocks for de, hsync, vsync and data.
- Bypass path: bypass goes through the window centre, so it carries the same spatial offset as erode/dilate. Result: erode/dilate/bypass outputs are spatially aligned with each other.
- Reset mid-frame: every output drops to 0 immediately. After release:
  - the first frame is processed only from the next rising vsync edge;
  - data before that edge follows the counters from 0 and may be spatially wrong, but must be 0x00/0xFF only.
- Extra de beyond H_DISP*V_DISP pixels: row saturates and col keeps wrapping; no overflow or X propagation.

Decomposition:
- Shared video package (morph_pkg), holding:
  - mode encodings MODE_BYPASS = 2'b00, MODE_ERODE = 2'b01, MODE_DILATE = 2'b10;
  - PIX_ON = 8'hFF, PIX_OFF = 8'h00.
- Sub-module matrix_3x3_1bit holds the line buffers, counters, padding and 3x3 window (clk1).
- The top module holds the vsync edge detect, mode latch, reduce and output stages, and the sync delay lines.

Test Plan:
All cases use H_DISP = 8, V_DISP = 6, de high for 8 clocks per line, with blanking between lines.
- Latency: single-clock de, hsync and vsync pulses -> each output pulse appears exactly 3 clocks later, same width.
- Erode, all-0xFF frame:
  - every output pixel at window rows 0..1 or cols 0..1 is 0x00;
  - all other pixels are 0xFF;
  - the count of 0xFF pixels in the frame is 4*6 = 24.
- Dilate, single 0xFF input at (row 3, col 4), all else 0x00 -> exactly 9 output pixels are 0xFF, at output indices rows 3..5, cols 4..6.
- Bypass, checkerboard input:
  - the output equals the input shifted by one line and one pixel;
  - the top and left padding pixels are 0x00.
- Mode switch: mode changes 01 -> 10 in the middle of frame 1 -> frame 1 is fully eroded; frame 2 is fully dilated.
- Reset: assert rst_n low for 2 clocks mid-line -> all outputs 0 during reset; the next frame after a vsync edge matches the golden model.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared types and constants for the binary morphology stage.
// Mode encodings, binary pixel codes and the 3x3 window layout.
package morph_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ERODE  = 2'b01;
  localparam logic [1:0] MODE_DILATE = 2'b10;

  localparam logic [7:0] PIX_ON  = 8'hFF;
  localparam logic [7:0] PIX_OFF = 8'h00;

  // Each row: bit 2 = column c-2 (oldest), bit 0 = column c (newest).
  typedef struct packed {
    logic [2:0] top;  // row r-2
    logic [2:0] mid;  // row r-1
    logic [2:0] bot;  // row r
  } win_t;

  function automatic logic [7:0] pix_code(input logic b);
    return b ? PIX_ON : PIX_OFF;
  endfunction

endpackage

// File: rtl/binary_morph_3x3_matrix.sv
// 1-bit line buffers, pixel counters and 3x3 window with top/left zero padding.
// Window registers one clock after the input pixel; everything holds while de is low.
module matrix_3x3_1bit
  import morph_pkg::*;
#(
  parameter logic [11:0] H_DISP = 12'd640,
  parameter logic [11:0] V_DISP = 12'd480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic de,
  input  logic pix,
  output win_t win
);

  localparam int AW = $clog2(H_DISP);

  logic [11:0]       col;
  logic [11:0]       row;
  logic [AW-1:0]     ci;
  logic [H_DISP-1:0] lb0;
  logic [H_DISP-1:0] lb1;
  logic              tap_top;
  logic              tap_mid;

  assign ci = col[AW-1:0];

  // Unwritten line-buffer bits are masked by the row 0/1 padding.
  assign tap_top = (row < 12'd2) ? 1'b0 : lb0[ci];
  assign tap_mid = (row == 12'd0) ? 1'b0 : lb1[ci];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 12'd0;
      row <= 12'd0;
    end else if (frame_start) begin
      col <= 12'd0;
      row <= 12'd0;
    end else if (de) begin
      if (col == H_DISP - 12'd1) begin
        col <= 12'd0;
        if (row != V_DISP - 12'd1) row <= row + 12'd1;
      end else begin
        col <= col + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (de) begin
      lb1[ci] <= pix;
      lb0[ci] <= lb1[ci];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (de) begin
      if (col == 12'd0) begin
        win.top <= {2'b00, tap_top};
        win.mid <= {2'b00, tap_mid};
        win.bot <= {2'b00, pix};
      end else begin
        win.top <= {win.top[1:0], tap_top};
        win.mid <= {win.mid[1:0], tap_mid};
        win.bot <= {win.bot[1:0], pix};
      end
    end
  end

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary erode/dilate/bypass on a 0x00/0xFF video stream, result at window centre.
// Fixed 3-clock latency on data and syncs; no backpressure, mode latched on vsync rise.
module binary_morph_3x3
  import morph_pkg::*;
#(
  parameter logic [11:0] H_DISP    = 12'd640,
  parameter logic [11:0] V_DISP    = 12'd480,
  parameter int          DLY_CYCLE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       seg_hsync,
  input  logic       seg_vsync,
  input  logic [7:0] seg_data,
  input  logic       seg_de,
  output logic       morph_hsync,
  output logic       morph_vsync,
  output logic [7:0] morph_data,
  output logic       morph_de
);

  logic                 vs_d;
  logic                 frame_start;
  logic [1:0]           mode_lat;
  win_t                 win;
  logic                 and9;
  logic                 or9;
  logic                 ctr;
  logic                 sel;
  logic [DLY_CYCLE-1:0] de_sr;
  logic [DLY_CYCLE-1:0] hs_sr;
  logic [DLY_CYCLE-1:0] vs_sr;
  logic [7:0]           data_q;
  logic                 unused_bits;

  assign unused_bits = ^seg_data[6:0];
  assign frame_start = seg_vsync & ~vs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      mode_lat <= MODE_BYPASS;
    end else begin
      vs_d <= seg_vsync;
      if (frame_start) mode_lat <= mode;
    end
  end

  matrix_3x3_1bit #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP)
  ) u_matrix (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .de          (seg_de),
    .pix         (seg_data[7]),
    .win         (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and9 <= 1'b0;
      or9  <= 1'b0;
      ctr  <= 1'b0;
    end else begin
      and9 <= &{win.top, win.mid, win.bot};
      or9  <= |{win.top, win.mid, win.bot};
      ctr  <= win.mid[1];
    end
  end

  always_comb begin
    sel = ctr;
    case (mode_lat)
      MODE_ERODE:  sel = and9;
      MODE_DILATE: sel = or9;
      default:     sel = ctr;
    endcase
  end

  // Syncs shift every clock; data uses the de tap aligned with the reduce stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sr  <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
      data_q <= PIX_OFF;
    end else begin
      de_sr  <= {de_sr[DLY_CYCLE-2:0], seg_de};
      hs_sr  <= {hs_sr[DLY_CYCLE-2:0], seg_hsync};
      vs_sr  <= {vs_sr[DLY_CYCLE-2:0], seg_vsync};
      data_q <= pix_code(de_sr[DLY_CYCLE-2] & sel);
    end
  end

  assign morph_de    = de_sr[DLY_CYCLE-1];
  assign morph_hsync = hs_sr[DLY_CYCLE-1];
  assign morph_vsync = vs_sr[DLY_CYCLE-1];
  assign morph_data  = data_q;

endmodule
